// File: rtl/stopwatch_pkg.sv
// Stopwatch controller shared definitions.
//   state_t     : controller state encoding
//   bcd_digit_t : one BCD digit
//   bcd4_t      : four BCD digits {d3,d2,d1,d0}
//   MAX_COUNT   : display value at which counting stops (99.99 s)
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAP,
        ST_STOP,
        ST_FULL
    } state_t;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd4_t;

    localparam logic [15:0] MAX_COUNT = 16'h9999;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: buttons in, counter-chain handshake, display/status out.
//   btn_ss, btn_lr : one-cycle debounced button pulses
//   cnt_digits     : live BCD digits from the external counter chain
//   cnt_enb        : count enable to the least-significant BCD counter
//   cnt_clr        : synchronous clear to every BCD counter
//   disp_digits    : digits to display (frozen lap value or live count)
//   running, lap_active, overflow : status flags
// modport slave  : the controller
// modport master : the surrounding system (buttons, counter chain, display)
interface stopwatch_ctrl_if;

    logic        btn_ss;
    logic        btn_lr;
    logic [15:0] cnt_digits;
    logic        cnt_enb;
    logic        cnt_clr;
    logic [15:0] disp_digits;
    logic        running;
    logic        lap_active;
    logic        overflow;

    modport slave (
        input  btn_ss, btn_lr, cnt_digits,
        output cnt_enb, cnt_clr, disp_digits, running, lap_active, overflow
    );

    modport master (
        output btn_ss, btn_lr, cnt_digits,
        input  cnt_enb, cnt_clr, disp_digits, running, lap_active, overflow
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the count tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : advance the count this cycle
//   clr        : force the count to 0 (wins over run)
//   tick       : high for the single cycle where a running count sits at DIV-1
// The count holds its phase whenever run is low, so a paused stopwatch
// resumes mid-tick instead of losing the partial interval.
module tick_prescaler #(
    parameter int DIV = 4  // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int            W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) count <= '0;
            else               count <= count + W'(1);
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop, lap freeze, reset-to-zero and 99.99 s stop,
// driving an external chain of four BCD counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stopwatch_ctrl_if.slave (buttons, counter chain, display, flags)
// Parameters CLK_HZ / TICK_HZ set the tick divider DIV = CLK_HZ/TICK_HZ (>= 2).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_ctrl_if.slave bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    state_t state;
    state_t state_nxt;
    bcd4_t  lap_reg;
    logic   lap_capture;
    logic   cnt_clr_q;
    logic   tick;
    logic   counting;
    logic   at_max;

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign at_max   = (bus.cnt_digits == MAX_COUNT);

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (counting),
        .clr   (state == ST_IDLE),
        .tick  (tick)
    );

    // Button checks come before the overflow check so a same-cycle press
    // wins; btn_ss is always tested first so it beats btn_lr.
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        lap_capture = 1'b0;
        unique case (state)
            ST_IDLE: if (bus.btn_ss) state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.btn_ss) begin
                    state_nxt = ST_STOP;
                end else if (bus.btn_lr) begin
                    state_nxt   = ST_LAP;
                    lap_capture = 1'b1;
                end else if (tick && at_max) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_LAP: begin
                if      (bus.btn_ss)     state_nxt = ST_STOP;
                else if (bus.btn_lr)     state_nxt = ST_RUN;
                else if (tick && at_max) state_nxt = ST_FULL;
            end
            ST_STOP: begin
                if      (bus.btn_ss) state_nxt = ST_RUN;
                else if (bus.btn_lr) state_nxt = ST_IDLE;
            end
            ST_FULL: if (bus.btn_lr) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // cnt_clr resets high so the counter chain is cleared on the first edge
    // after reset release, then pulses once on every later entry into IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lap_reg   <= '0;
            cnt_clr_q <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt_clr_q <= (state_nxt == ST_IDLE) && (state != ST_IDLE);
            if (lap_capture) lap_reg <= bus.cnt_digits;
        end
    end

    assign bus.cnt_enb     = tick && counting && !at_max;
    assign bus.cnt_clr     = cnt_clr_q;
    assign bus.disp_digits = (state == ST_LAP) ? lap_reg : bus.cnt_digits;
    assign bus.running     = counting;
    assign bus.lap_active  = (state == ST_LAP);
    assign bus.overflow    = (state == ST_FULL);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DIV = 4.
// The four-digit BCD counter chain lives in the bench and is fed by the
// controller's cnt_enb/cnt_clr. A reference model tracks the stopwatch as a
// mode plus integer centiseconds, lap value and cycles spent running.
module tb_stopwatch_ctrl;

    localparam int CLK_HZ  = 400;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3, M_FULL = 4;

    logic clk;
    logic rst_n;
    logic preload_req;
    logic [15:0] preload_val;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    int m_st, m_cnt, m_lap, m_runcyc;
    bit m_clr;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic int from_bcd(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // Counter chain: four cascaded decimal digits, clear wins, then preload.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           bus.cnt_digits <= 16'h0000;
        else if (bus.cnt_clr) bus.cnt_digits <= 16'h0000;
        else if (preload_req) bus.cnt_digits <= preload_val;
        else if (bus.cnt_enb) bus.cnt_digits <= to_bcd((from_bcd(bus.cnt_digits) + 1) % 10000);
    end

    function automatic bit m_running();
        return (m_st == M_RUN) || (m_st == M_LAP);
    endfunction

    function automatic bit m_tick();
        return m_running() && (m_runcyc % DIV == DIV - 1);
    endfunction

    function automatic bit m_enb();
        return m_tick() && (m_cnt != 9999);
    endfunction

    function automatic logic [20:0] exp_vec();
        return {m_enb(), m_clr, m_running(), m_st == M_LAP, m_st == M_FULL,
                to_bcd((m_st == M_LAP) ? m_lap : m_cnt)};
    endfunction

    wire [20:0] act_vec = {bus.cnt_enb, bus.cnt_clr, bus.running, bus.lap_active,
                           bus.overflow, bus.disp_digits};

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_lap = 0; m_runcyc = 0; m_clr = 1'b1;
    endtask

    task automatic model_step(input bit ss, input bit lr, input bit pl, input int pv);
        int  nst;
        bit  full;
        nst  = m_st;
        full = m_tick() && (m_cnt == 9999);
        case (m_st)
            M_IDLE: if (ss) nst = M_RUN;
            M_RUN:  if (ss) nst = M_STOP;
                    else if (lr) begin nst = M_LAP; m_lap = m_cnt; end
                    else if (full) nst = M_FULL;
            M_LAP:  if (ss) nst = M_STOP; else if (lr) nst = M_RUN; else if (full) nst = M_FULL;
            M_STOP: if (ss) nst = M_RUN; else if (lr) nst = M_IDLE;
            M_FULL: if (lr) nst = M_IDLE;
            default: nst = M_IDLE;
        endcase
        if (m_clr)        m_cnt = 0;
        else if (pl)      m_cnt = pv;
        else if (m_enb()) m_cnt = m_cnt + 1;
        if (m_st == M_IDLE)   m_runcyc = 0;
        else if (m_running()) m_runcyc = m_runcyc + 1;
        m_clr = (nst == M_IDLE) && (m_st != M_IDLE);
        m_st  = nst;
    endtask

    // One clock cycle: drive buttons before the edge, update the model at the
    // edge, return at the following falling edge with outputs settled.
    task automatic step(input bit ss, input bit lr, input bit pl = 1'b0, input int pv = 0);
        bus.btn_ss  = ss;
        bus.btn_lr  = lr;
        preload_req = pl;
        preload_val = to_bcd(pv);
        @(posedge clk);
        model_step(ss, lr, pl, pv);
        @(negedge clk);
        bus.btn_ss  = 1'b0;
        bus.btn_lr  = 1'b0;
        preload_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (act_vec !== 21'h08_0000) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", act_vec, 21'h08_0000);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.cnt_clr !== 1'b1) begin
            n_fail++; $display("FAIL reset_clr_held: got %b expected 1", bus.cnt_clr);
        end
        @(negedge clk);
        step(1'b0, 1'b0);
        n_checks++;
        if (act_vec !== 21'h00_0000 || act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_basic_run();
        int pulses = 0;
        repeat (8) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n_checks++;
        if (bus.running !== 1'b1) begin
            n_fail++; $display("FAIL run_start: running got %b expected 1", bus.running);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus.cnt_enb === 1'b1) pulses++;
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL run_cycle %0d: got %h expected %h", i, act_vec, exp_vec());
            end
            step(1'b0, 1'b0);
        end
        n_checks++;
        if (pulses != 10) begin
            n_fail++; $display("FAIL run_enb_pulses: got %0d expected 10", pulses);
        end
        n_checks++;
        if (bus.disp_digits !== 16'h0010) begin
            n_fail++; $display("FAIL run_40_cycles: got %h expected 0010", bus.disp_digits);
        end
    endtask

    task automatic test_lap();
        int budget = 0;
        while (m_cnt != 25 && budget < 200) begin
            step(1'b0, 1'b0);
            budget++;
        end
        n_checks++;
        if (budget >= 200 || bus.cnt_digits !== 16'h0025) begin
            n_fail++; $display("FAIL lap_reach_25: got %h expected 0025", bus.cnt_digits);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (bus.lap_active !== 1'b1 || bus.disp_digits !== 16'h0025) begin
            n_fail++; $display("FAIL lap_freeze: got lap=%b disp=%h expected lap=1 disp=0025",
                               bus.lap_active, bus.disp_digits);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL lap_cycle %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        n_checks++;
        if (bus.disp_digits !== 16'h0025 || bus.cnt_digits === 16'h0025) begin
            n_fail++; $display("FAIL lap_counting: got disp=%h cnt=%h expected disp=0025 cnt advanced",
                               bus.disp_digits, bus.cnt_digits);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (bus.lap_active !== 1'b0 || bus.disp_digits !== to_bcd(m_cnt)) begin
            n_fail++; $display("FAIL lap_release: got lap=%b disp=%h expected lap=0 disp=%h",
                               bus.lap_active, bus.disp_digits, to_bcd(m_cnt));
        end
    endtask

    task automatic test_stop_resume();
        int pulses = 0;
        int held;
        repeat (6) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        held = m_cnt;
        for (int i = 0; i < 12; i++) begin
            if (bus.cnt_enb !== 1'b0) pulses++;
            step(1'b0, 1'b0);
        end
        n_checks++;
        if (pulses != 0 || bus.running !== 1'b0 || bus.disp_digits !== to_bcd(held)) begin
            n_fail++; $display("FAIL stop_hold: got enb=%0d run=%b disp=%h expected 0 0 %h",
                               pulses, bus.running, bus.disp_digits, to_bcd(held));
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL resume_cycle %0d: got %h expected %h", i, act_vec, exp_vec());
            end
            step(1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        n_checks++;
        if (bus.cnt_clr !== 1'b1 || bus.running !== 1'b0) begin
            n_fail++; $display("FAIL stop_to_idle: got clr=%b run=%b expected clr=1 run=0",
                               bus.cnt_clr, bus.running);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (bus.cnt_clr !== 1'b0 || bus.disp_digits !== 16'h0000) begin
            n_fail++; $display("FAIL idle_cleared: got clr=%b disp=%h expected clr=0 disp=0000",
                               bus.cnt_clr, bus.disp_digits);
        end
    endtask

    task automatic test_overflow();
        int budget = 0;
        int pulses = 0;
        step(1'b0, 1'b0, 1'b1, 9998);
        step(1'b1, 1'b0);
        while (m_st != M_FULL && budget < 40) begin
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL ovf_cycle %0d: got %h expected %h", budget, act_vec, exp_vec());
            end
            step(1'b0, 1'b0);
            budget++;
        end
        n_checks++;
        if (budget >= 40 || bus.overflow !== 1'b1 || bus.disp_digits !== 16'h9999) begin
            n_fail++; $display("FAIL ovf_reach: got ovf=%b disp=%h expected ovf=1 disp=9999",
                               bus.overflow, bus.disp_digits);
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (bus.cnt_enb !== 1'b0) pulses++;
            step(1'b0, 1'b0);
        end
        n_checks++;
        if (bus.overflow !== 1'b1 || pulses != 0 || bus.cnt_digits !== 16'h9999) begin
            n_fail++; $display("FAIL ovf_hold: got ovf=%b enb=%0d cnt=%h expected 1 0 9999",
                               bus.overflow, pulses, bus.cnt_digits);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.cnt_clr !== 1'b1) begin
            n_fail++; $display("FAIL ovf_exit: got ovf=%b clr=%b expected 0 1", bus.overflow, bus.cnt_clr);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (bus.disp_digits !== 16'h0000) begin
            n_fail++; $display("FAIL ovf_cleared: got %h expected 0000", bus.disp_digits);
        end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if (bus.running !== 1'b0 || bus.lap_active !== 1'b0 || act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL both_buttons: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid_lap();
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (act_vec !== 21'h08_0000) begin
            n_fail++; $display("FAIL reset_mid_lap: got %h expected %h", act_vec, 21'h08_0000);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_mid_lap_release: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        bit ss, lr, pl;
        for (int i = 0; i < 4000; i++) begin
            ss = ($urandom_range(0, 39) == 0);
            lr = ($urandom_range(0, 39) == 0);
            pl = (m_st == M_IDLE) && !m_clr && ($urandom_range(0, 3) == 0);
            step(ss, lr, pl, int'($urandom_range(9975, 9999)));
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.btn_ss  = 1'b0;
        bus.btn_lr  = 1'b0;
        preload_req = 1'b0;
        preload_val = 16'h0000;
        model_reset();
        test_reset();
        test_basic_run();
        test_lap();
        test_stop_resume();
        test_overflow();
        test_same_cycle();
        test_reset_mid_lap();
        apply_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, count tick rate in Hz (0.01 s resolution); DIV = CLK_HZ/TICK_HZ, DIV >= 2.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port btn_ss  input  1  start/stop request, one-cycle pulse, already debounced.
REQ-006 SHALL have port btn_lr  input  1  lap/reset request, one-cycle pulse, already debounced.
REQ-007 SHALL have port cnt_digits  input  16  live BCD digits {d3,d2,d1,d0} from the counter_bcd chain.
REQ-008 SHALL have port cnt_enb  output  1  count enable to the least-significant counter_bcd.
REQ-009 SHALL have port cnt_clr  output  1  synchronous clear to all counter_bcd rst inputs.
REQ-010 SHALL have port disp_digits  output  16  BCD digits to display.
REQ-011 SHALL have ports running, lap_active, overflow  output  1 each  status flags.

Function
REQ-012 SHALL implement states IDLE, RUN, LAP, STOP, FULL.
REQ-013 IDLE: btn_ss -> RUN; btn_lr ignored.
REQ-014 RUN: btn_ss -> STOP; btn_lr -> LAP, capturing cnt_digits into lap_reg on the same edge.
REQ-015 LAP: btn_ss -> STOP; btn_lr -> RUN (freeze released); counting continues in LAP.
REQ-016 STOP: btn_ss -> RUN (resume, no clear); btn_lr -> IDLE.
REQ-017 RUN/LAP: cnt_digits == 16'h9999 with tick -> FULL instead of counting; btn_ss/btn_lr same cycle take precedence.
REQ-018 FULL: btn_lr -> IDLE; btn_ss ignored; counter holds 99.99.
REQ-019 btn_ss and btn_lr in same cycle: btn_ss SHALL win, btn_lr dropped.
REQ-020 State change SHALL take effect on the clock edge sampling the button pulse (one-cycle latency).
REQ-021 Prescaler 0..DIV-1; tick = 1 for exactly one cycle when count == DIV-1, then wraps to 0.
REQ-022 Prescaler SHALL advance only in RUN/LAP, hold its value in STOP/FULL, be forced to 0 in IDLE.
REQ-023 cnt_enb = tick AND state in {RUN,LAP} AND cnt_digits != 16'h9999 (combinational).
REQ-024 cnt_clr SHALL be registered, high exactly one cycle: the first cycle after any transition into IDLE.
REQ-025 disp_digits = lap_reg in LAP, else cnt_digits.
REQ-026 running = state in {RUN,LAP}; lap_active = (state == LAP); overflow = (state == FULL).

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, prescaler 0, lap_reg 0, cnt_clr 1.
REQ-028 After rst_n release, cnt_clr SHALL deassert at the first rising edge; all other outputs follow REQ-023..026 (cnt_enb 0, flags 0).
REQ-029 rst_n asserted mid-count SHALL abort the state immediately; no partial lap capture.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state enum, BCD-digit typedef (logic [3:0]) and constant MAX_COUNT = 16'h9999.
REQ-031 Prescaler SHALL be a sub-module tick_prescaler (params DIV; ports clk, rst_n, run, clr, tick).

Verification (CLK_HZ=400, TICK_HZ=100, DIV=4, four counter_bcd instances chained)
REQ-032 Reset, btn_ss at cycle 10 -> running=1 cycle 11; cnt_enb pulses every 4 cycles; after 40 cycles in RUN disp_digits=16'h0010.
REQ-033 In RUN at 00.25 pulse btn_lr -> lap_active=1, disp_digits frozen at 16'h0025 while cnt_digits advances; btn_lr again -> disp_digits live.
REQ-034 RUN -> btn_ss -> STOP: cnt_enb 0, digits held; btn_ss -> resume from held value and held prescaler phase; btn_lr in STOP -> IDLE, cnt_clr one-cycle pulse, digits 16'h0000.
REQ-035 Preload chain to 99.98, run -> reaches 16'h9999, next tick overflow=1, no wrap to 0000; btn_ss ignored; btn_lr -> IDLE, clear.
REQ-036 btn_ss and btn_lr same cycle in RUN -> STOP, lap_reg unchanged; rst_n low mid-LAP -> IDLE, lap_reg 0, cnt_clr 1 asynchronously.
